fir_mac_ctrl: RTL

Time-multiplexed controller for the 4-tap FIR filter. It shares one 4x4 multiplier and a 10-bit accumulator across all taps instead of using four parallel multipliers. It accepts 4-bit samples over a valid/ready handshake, keeps the 4-deep sample delay line, and sequences one tap product per cycle. It presents the 10-bit filter result over a valid/ready handshake and exposes run-time-loadable coefficients.

---
 rtl/fir_mac_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: time-multiplexed 4-tap FIR, one shared 4x4 multiplier.
// Ports: x/in_valid/in_ready in, q/out_valid/out_ready out, cfg_* coefs, clr flush, busy.
module fir_mac_ctrl #(
  parameter logic [3:0] COEF0 = 4'd1,
  parameter logic [3:0] COEF1 = 4'd2,
  parameter logic [3:0] COEF2 = 4'd3,
  parameter logic [3:0] COEF3 = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] q,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [3:0] cfg_data,
  output logic       cfg_drop,
  input  logic       clr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [3:0] d [4];
  logic [3:0] c [4];
  logic [9:0] acc;
  logic [1:0] idx;

  logic [7:0] prod;
  logic [9:0] sum;

  logic       accept;
  logic       cfg_wr;
  logic       step;
  logic       last;
  logic       take;

  assign prod = {4'd0, c[idx]} * {4'd0, d[idx]};
  assign sum  = acc + {2'b00, prod};

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) & ~cfg_we & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // clr overrides everything; in IDLE a cfg write wins over a sample
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cfg_wr   = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    take     = 1'b0;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            cfg_wr = 1'b1;
          end else if (in_valid) begin
            accept   = 1'b1;
            state_nx = MAC;
          end
        end
        MAC: begin
          step = 1'b1;
          if (idx == 2'd3) begin
            last     = 1'b1;
            state_nx = DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            take     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        d[i] <= '0;
      end
      c[0]      <= COEF0;
      c[1]      <= COEF1;
      c[2]      <= COEF2;
      c[3]      <= COEF3;
      acc       <= '0;
      idx       <= '0;
      q         <= '0;
      out_valid <= 1'b0;
      cfg_drop  <= 1'b0;
    end else begin
      // a write that lands while busy is reported, unless clr swallows it
      cfg_drop <= cfg_we & ~clr & (state != IDLE);
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          d[i] <= '0;
        end
        acc       <= '0;
        idx       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (cfg_wr) begin
          c[cfg_addr] <= cfg_data;
        end
        if (accept) begin
          d[3] <= d[2];
          d[2] <= d[1];
          d[1] <= d[0];
          d[0] <= x;
          acc  <= '0;
          idx  <= '0;
        end
        if (step) begin
          acc <= sum;
          idx <= idx + 2'd1;
        end
        if (last) begin
          q         <= sum;
          out_valid <= 1'b1;
        end
        if (take) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
